// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//   Round-robin arbiter/sequencer that shares one APB master between NUM_REQ
//   independent requesters. One request is granted at a time; its command is
//   latched and presented to the master (transfer/WRITE_READ/apb_addr/
//   apb_wdata). Completion is detected by observing PENABLE && PREADY on the
//   bus. The read data and error status are then returned to the granted
//   requester. A per-access watchdog forces an error completion when the
//   slave never responds.
//
// Ports
//   PCLK, PRESET           clock (rising edge) / async active-high reset
//   req_valid/req_write    per-requester request level and direction
//   req_addr/req_wdata     packed per-requester address / write data
//   req_ready              1-cycle pulse when request i is accepted
//   rsp_valid              1-cycle pulse when response i is presented
//   rsp_rdata/rsp_err      response payload, held until the next response
//   grant_id               index of the current/last grant
//   transfer/WRITE_READ/
//   apb_addr/apb_wdata     command to the APB master
//   apb_rdata/PSLVERR      result from the APB master
//   PENABLE/PREADY         observed bus handshake
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                                PCLK,
    input  logic                                PRESET,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*(ADDR_WIDTH+1)-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id,
    output logic                                transfer,
    output logic                                WRITE_READ,
    output logic [ADDR_WIDTH:0]                 apb_addr,
    output logic [DATA_WIDTH-1:0]               apb_wdata,
    input  logic [DATA_WIDTH-1:0]               apb_rdata,
    input  logic                                PSLVERR,
    input  logic                                PENABLE,
    input  logic                                PREADY
);

    localparam int unsigned NR  = NUM_REQ;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam int unsigned IDW = $clog2(NUM_REQ);
    // A zero TIMEOUT would give a zero-width counter; keep one bit instead.
    localparam int unsigned CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TMO_EN   = (TIMEOUT > 0);
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         last_q,  last_d;
    logic [IDW-1:0]         grant_q, grant_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH:0]    addr_q,  addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q,   err_d;
    logic [CW-1:0]          cnt_q,   cnt_d;

    logic [ADDR_WIDTH:0]    addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    logic                   win_found;
    logic [IDW-1:0]         win_idx;
    logic                   bus_done;
    logic                   tmo_hit;

    // Unpack the flat request buses into per-requester views.
    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            addr_arr[i]  = req_addr[i*AW1 +: AW1];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first pending requester after the last winner.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = last_q;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx = (32'(last_q) + i) % NR;
            if (!win_found && req_valid[IDW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    assign bus_done = PENABLE && PREADY;
    assign tmo_hit  = TMO_EN && (cnt_q == TMO_LAST) && !bus_done;

    // ---------------------------------------------------------------- state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (win_found) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus_done || tmo_hit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        last_d  = last_q;
        grant_d = grant_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    last_d  = win_idx;
                    grant_d = win_idx;
                    write_d = req_write[win_idx];
                    addr_d  = addr_arr[win_idx];
                    wdata_d = wdata_arr[win_idx];
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                if (bus_done) begin
                    rdata_d = write_q ? '0 : apb_rdata;
                    err_d   = PSLVERR;
                end else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            last_q  <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            last_q  <= last_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        transfer   = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                req_ready[grant_q] = 1'b1;
                transfer           = 1'b1;
            end
            // Drop transfer in the completion cycle so the master returns
            // to idle instead of chaining a second access.
            ST_WAIT:  transfer = !bus_done;
            ST_RESP:  rsp_valid[grant_q] = 1'b1;
            default: ;
        endcase
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
        grant_id   = grant_q;
        WRITE_READ = write_q;
        apb_addr   = addr_q;
        apb_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int AW1 = AW + 1;

    logic                 PCLK;
    logic                 PRESET;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_write;
    logic [NR*AW1-1:0]    req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic [1:0]           grant_id;
    logic                 transfer;
    logic                 WRITE_READ;
    logic [AW:0]          apb_addr;
    logic [DW-1:0]        apb_wdata;
    logic [DW-1:0]        apb_rdata;
    logic                 PSLVERR;
    logic                 PENABLE;
    logic                 PREADY;

    int tests  = 0;
    int errors = 0;

    apb_req_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .grant_id   (grant_id),
        .transfer   (transfer),
        .WRITE_READ (WRITE_READ),
        .apb_addr   (apb_addr),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata),
        .PSLVERR    (PSLVERR),
        .PENABLE    (PENABLE),
        .PREADY     (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- APB master + slave model ----------------
    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} mst_t;
    mst_t        m_state;
    int          acc_cnt;
    int          wait_states   = 0;
    logic        stuck         = 1'b0;
    logic        rd_override_en = 1'b0;
    logic [DW-1:0] rd_override = '0;
    logic        err_en        = 1'b0;
    logic [AW:0] err_addr      = '0;

    function automatic logic [DW-1:0] slave_data(input logic [AW:0] a);
        return {a[15:0] ^ 16'hC3C3, a[15:0]};
    endfunction

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_state <= M_IDLE;
            acc_cnt <= 0;
        end else begin
            case (m_state)
                M_IDLE:   if (transfer) m_state <= M_SETUP;
                M_SETUP:  begin m_state <= M_ACCESS; acc_cnt <= 0; end
                M_ACCESS: begin
                    acc_cnt <= acc_cnt + 1;
                    if (PREADY) m_state <= transfer ? M_SETUP : M_IDLE;
                end
                default:  m_state <= M_IDLE;
            endcase
        end
    end

    assign PENABLE   = (m_state == M_ACCESS);
    assign PREADY    = (m_state == M_ACCESS) && !stuck && (acc_cnt >= wait_states);
    assign apb_rdata = rd_override_en ? rd_override : slave_data(apb_addr);
    assign PSLVERR   = err_en && PENABLE && (apb_addr == err_addr);

    // ---------------- scoreboard ----------------
    typedef struct {
        int            id;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    always @(negedge PCLK) begin
        if (rsp_valid !== '0) begin
            tests++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", rsp_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_valid !== (4'b0001 << e.id) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp_check: got valid=%b rdata=%h err=%b, expected valid=%b rdata=%h err=%b",
                             rsp_valid, rsp_rdata, rsp_err, 4'b0001 << e.id, e.rdata, e.err);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic wr, input logic [AW:0] a, input logic [DW-1:0] d);
        req_write[id]          = wr;
        req_addr[id*AW1 +: AW1] = a;
        req_wdata[id*DW +: DW]  = d;
    endtask

    task automatic wait_any_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge PCLK);
            if (req_ready !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge PCLK);
            c++;
        end
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge PCLK);
        tests++;
        if ({req_ready, rsp_valid, transfer} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b transfer=%b, expected all 0",
                     req_ready, rsp_valid, transfer);
        end
        tests++;
        if ({rsp_rdata, rsp_err, grant_id, WRITE_READ, apb_addr, apb_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h err=%b gid=%0d wr=%b addr=%h wdata=%h, expected all 0",
                     rsp_rdata, rsp_err, grant_id, WRITE_READ, apb_addr, apb_wdata);
        end
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_contention();
        int  order [5] = '{0, 1, 2, 3, 0};
        bit  ok;
        set_req(0, 1'b0, 33'h100, 32'h0);
        set_req(1, 1'b1, 33'h104, 32'h1111_0001);
        set_req(2, 1'b0, 33'h108, 32'h0);
        set_req(3, 1'b1, 33'h10C, 32'h3333_0003);
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.id    = order[k];
            e.rdata = req_write[order[k]] ? '0 : slave_data(req_addr[order[k]*AW1 +: AW1]);
            e.err   = 1'b0;
            sb.push_back(e);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_any_ready(20, ok);
            tests++;
            if (!ok) begin
                errors++;
                $display("FAIL contention_timeout: grant %0d never arrived", k);
                break;
            end
            if (k == 4) req_valid = '0;
            if (req_ready !== (4'b0001 << order[k]) || grant_id !== 2'(order[k])) begin
                errors++;
                $display("FAIL contention_order: grant %0d ready=%b gid=%0d, expected requester %0d",
                         k, req_ready, grant_id, order[k]);
            end
        end
        req_valid = '0;
        wait_sb_empty("contention", 40);
    endtask

    task automatic test_single_write();
        bit   ok;
        exp_t e;
        set_req(1, 1'b1, 33'h10, 32'h0000_A5A5);
        e.id = 1; e.rdata = '0; e.err = 1'b0;
        sb.push_back(e);
        req_valid = 4'b0010;
        wait_any_ready(10, ok);
        req_valid = '0;
        tests++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL write_ready: ready=%b seen=%0b, expected 0010", req_ready, ok);
        end
        tests++;
        if (apb_addr !== 33'h10 || WRITE_READ !== 1'b1 || apb_wdata !== 32'h0000_A5A5 || transfer !== 1'b1) begin
            errors++;
            $display("FAIL write_cmd: addr=%h wr=%b wdata=%h transfer=%b, expected 10 1 0000a5a5 1",
                     apb_addr, WRITE_READ, apb_wdata, transfer);
        end
        wait_sb_empty("write", 20);
    endtask

    task automatic test_single_read();
        bit   ok;
        exp_t e;
        rd_override_en = 1'b1;
        rd_override    = 32'hDEAD_BEEF;
        wait_states    = 2;
        set_req(0, 1'b0, 33'h20, 32'h0);
        e.id = 0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b0;
        sb.push_back(e);
        req_valid = 4'b0001;
        wait_any_ready(10, ok);
        req_valid = '0;
        tests++;
        if (!ok || req_ready !== 4'b0001 || apb_addr !== 33'h20 || WRITE_READ !== 1'b0) begin
            errors++;
            $display("FAIL read_cmd: ready=%b addr=%h wr=%b, expected 0001 20 0",
                     req_ready, apb_addr, WRITE_READ);
        end
        wait_sb_empty("read", 20);
        rd_override_en = 1'b0;
        wait_states    = 0;
    endtask

    task automatic test_error();
        bit   ok;
        exp_t e;
        err_en   = 1'b1;
        err_addr = 33'h30;
        set_req(2, 1'b0, 33'h30, 32'h0);
        e.id = 2; e.rdata = slave_data(33'h30); e.err = 1'b1;
        sb.push_back(e);
        req_valid = 4'b0100;
        wait_any_ready(10, ok);
        req_valid = '0;
        tests++;
        if (!ok || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL error_grant: gid=%0d seen=%0b, expected 2", grant_id, ok);
        end
        wait_sb_empty("error", 20);
        err_en = 1'b0;
        repeat (3) @(negedge PCLK);
        tests++;
        if (rsp_err !== 1'b1 || rsp_rdata !== slave_data(33'h30)) begin
            errors++;
            $display("FAIL error_hold: err=%b rdata=%h, expected 1 %h", rsp_err, rsp_rdata, slave_data(33'h30));
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        int   cyc;
        exp_t e;
        stuck = 1'b1;
        set_req(3, 1'b0, 33'h40, 32'h0);
        e.id = 3; e.rdata = '0; e.err = 1'b1;
        sb.push_back(e);
        req_valid = 4'b1000;
        wait_any_ready(10, ok);
        req_valid = '0;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge PCLK);
            if (rsp_valid !== '0) begin
                cyc = c;
                break;
            end
        end
        tests++;
        if (!ok || cyc != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency: response %0d cycles after ready (seen=%0b), expected %0d",
                     cyc, ok, TO + 1);
        end
        stuck = 1'b0;
        wait_sb_empty("timeout", 5);
        repeat (2) @(negedge PCLK);
        set_req(0, 1'b1, 33'h44, 32'h0000_1234);
        e.id = 0; e.rdata = '0; e.err = 1'b0;
        sb.push_back(e);
        req_valid = 4'b0001;
        wait_any_ready(10, ok);
        req_valid = '0;
        tests++;
        if (!ok || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_next: ready=%b seen=%0b, expected 0001", req_ready, ok);
        end
        wait_sb_empty("timeout_next", 20);
    endtask

    task automatic test_reset_mid_access();
        bit   ok;
        int   seen;
        exp_t e;
        set_req(1, 1'b0, 33'h50, 32'h0);
        req_valid = 4'b0010;
        wait_any_ready(10, ok);
        req_valid = '0;
        repeat (2) @(negedge PCLK);
        #1 PRESET = 1'b1;
        @(negedge PCLK);
        tests++;
        if ({req_ready, rsp_valid, transfer, rsp_rdata, rsp_err, grant_id, WRITE_READ, apb_addr, apb_wdata} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ready=%b rsp=%b tr=%b gid=%0d addr=%h, expected all 0",
                     req_ready, rsp_valid, transfer, grant_id, apb_addr);
        end
        PRESET = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge PCLK);
            if (rsp_valid !== '0) seen++;
        end
        tests++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_rsp: %0d responses after reset, expected 0", seen);
        end
        set_req(1, 1'b1, 33'h60, 32'h0000_0060);
        set_req(2, 1'b1, 33'h64, 32'h0000_0064);
        e.id = 1; e.rdata = '0; e.err = 1'b0;
        sb.push_back(e);
        req_valid = 4'b0110;
        wait_any_ready(10, ok);
        req_valid = '0;
        tests++;
        if (!ok || req_ready !== 4'b0010 || apb_addr !== 33'h60) begin
            errors++;
            $display("FAIL midreset_priority: ready=%b addr=%h, expected 0010 60", req_ready, apb_addr);
        end
        wait_sb_empty("midreset", 20);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_single_read();
        test_error();
        test_timeout();
        test_reset_mid_access();
        repeat (4) @(negedge PCLK);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
